// File: rtl/rfid_uart_pkg.sv
// rtl/rfid_uart_pkg.sv - shared types and ASCII helpers for the tag reporter
package rfid_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} rpt_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n - 4'd10};
  endfunction

endpackage

// File: rtl/rfid_tag_reporter.sv
// rtl/rfid_tag_reporter.sv - formats tag IDs as uppercase hex + CR LF for the UART
module rfid_tag_reporter
  import rfid_uart_pkg::*;
#(
  parameter int ID_BYTES     = 5,
  parameter int DEDUP_CYCLES = 0,
  parameter int DROP_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tag_valid,
  input  logic [8*ID_BYTES-1:0]   tag_id,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic                    rpt_busy,
  output logic                    tag_drop,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int ID_W   = 8 * ID_BYTES;
  localparam int NCHARS = 2 * ID_BYTES + 2;
  localparam int IDX_W  = $clog2(NCHARS);
  localparam int WIN_W  = (DEDUP_CYCLES > 0) ? $clog2(DEDUP_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHARS - 1);
  localparam logic [WIN_W-1:0] WIN_RELOAD = WIN_W'(DEDUP_CYCLES);

  function automatic logic [7:0] char_at(input logic [ID_W-1:0] id, input logic [IDX_W-1:0] idx);
    logic [ID_W-1:0] sh;
    sh = '0;
    if (int'(idx) < 2 * ID_BYTES) begin
      sh = id >> (4 * (2 * ID_BYTES - 1 - int'(idx)));
      return nib2ascii(sh[3:0]);
    end
    if (int'(idx) == 2 * ID_BYTES) return ASCII_CR;
    return ASCII_LF;
  endfunction

  rpt_state_t        state_q, state_d;
  logic [ID_W-1:0]   slot_q, slot_d, active_q, active_d, last_id_q, last_id_d;
  logic              slot_full_q, slot_full_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              tx_start_q, tx_start_d, rpt_busy_q, rpt_busy_d, tag_drop_q, tag_drop_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              move, slot_free, dedup_hit, capture, drop;

  always_comb begin
    move      = (state_q == IDLE) && slot_full_q;
    // The slot is reusable in the very cycle its contents move to active_id.
    slot_free = !slot_full_q || move;
    dedup_hit = (DEDUP_CYCLES > 0) && tag_valid && (tag_id == last_id_q) && (win_q != '0);
    capture   = tag_valid && !dedup_hit && slot_free;
    drop      = tag_valid && !dedup_hit && !slot_free;
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    slot_full_d = slot_full_q;
    active_d    = active_q;
    idx_d       = idx_q;
    last_id_d   = last_id_q;
    win_d       = win_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    tag_drop_d  = 1'b0;
    drop_cnt_d  = drop_cnt_q;

    unique case (state_q)
      IDLE: if (slot_full_q) begin
        active_d    = slot_q;
        slot_full_d = 1'b0;
        idx_d       = '0;
        state_d     = START;
        tx_start_d  = 1'b1;
        tx_data_d   = char_at(slot_q, '0);
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d      = idx_q + 1'b1;
          state_d    = START;
          tx_start_d = 1'b1;
          tx_data_d  = char_at(active_q, idx_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      slot_d      = tag_id;
      slot_full_d = 1'b1;
      last_id_d   = tag_id;
      win_d       = WIN_RELOAD;
    end else if (dedup_hit) begin
      win_d = WIN_RELOAD;
    end else if (win_q != '0) begin
      win_d = win_q - 1'b1;
    end

    if (drop) begin
      tag_drop_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    rpt_busy_d = (state_d != IDLE) || slot_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      slot_full_q <= 1'b0;
      active_q    <= '0;
      idx_q       <= '0;
      last_id_q   <= '0;
      win_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      rpt_busy_q  <= 1'b0;
      tag_drop_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      slot_full_q <= slot_full_d;
      active_q    <= active_d;
      idx_q       <= idx_d;
      last_id_q   <= last_id_d;
      win_q       <= win_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      rpt_busy_q  <= rpt_busy_d;
      tag_drop_q  <= tag_drop_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign rpt_busy = rpt_busy_q;
  assign tag_drop = tag_drop_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_rfid_tag_reporter.sv
// tb/tb_rfid_tag_reporter.sv - self-checking bench for rfid_tag_reporter with a behavioural UART
module tb_rfid_tag_reporter;

  localparam int ID_BYTES = 5;
  localparam int DEDUP    = 100;
  localparam int DROP_W   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  tag_valid = 1'b0;
  logic [8*ID_BYTES-1:0] tag_id = '0;
  logic                  tx_busy = 1'b0;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  rpt_busy;
  logic                  tag_drop;
  logic [DROP_W-1:0]     drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int drop_pulses = 0;
  int ucnt = 0;
  logic [7:0] got[$];
  logic [7:0] expq[$];

  rfid_tag_reporter #(.ID_BYTES(ID_BYTES), .DEDUP_CYCLES(DEDUP), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst_n(rst_n), .tag_valid(tag_valid), .tag_id(tag_id), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .rpt_busy(rpt_busy), .tag_drop(tag_drop),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // UART stand-in: latches the byte on tx_start, busy from the next cycle for 1..6 cycles
  always @(posedge clk) begin
    if (tx_start === 1'b1) begin
      got.push_back(tx_data);
      tx_busy <= 1'b1;
      ucnt    <= $urandom_range(6, 1);
    end else if (ucnt > 1) begin
      ucnt <= ucnt - 1;
    end else begin
      ucnt    <= 0;
      tx_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_vec++;
      assert (!(tx_start === 1'b1 && tx_busy === 1'b1))
      else begin
        n_err++;
        $error("FAIL start_while_busy observed=1 expected=0");
      end
    end
    if (tag_drop === 1'b1) drop_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*ID_BYTES-1:0] rnd_id();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[8*ID_BYTES-1:0];
  endfunction

  task automatic strobe(input logic [8*ID_BYTES-1:0] id);
    tag_id    = id;
    tag_valid = 1'b1;
    tick();
    tag_valid = 1'b0;
  endtask

  // Expected report text: the ID printed as uppercase hex, then CR LF
  task automatic push_fmt(input logic [8*ID_BYTES-1:0] id);
    string s;
    s = $sformatf("%0h", id);
    while (s.len() < 2 * ID_BYTES) s = {"0", s};
    s = s.toupper();
    for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
    expq.push_back(8'd13);
    expq.push_back(8'd10);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(rpt_busy === 1'b0 && tx_busy === 1'b0) && n < 5000) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < 5000), 64'd1);
    chk({tag, "_rpt_busy"}, 64'(rpt_busy), 64'd0);
  endtask

  task automatic check_report(input string tag);
    int m;
    chk({tag, "_len"}, 64'(got.size()), 64'(expq.size()));
    m = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s_b%0d", tag, i), 64'(got[i]), 64'(expq[i]));
    got.delete();
    expq.delete();
  endtask

  task automatic do_reset();
    int n;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    while (tx_busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    got.delete();
    expq.delete();
    drop_pulses = 0;
  endtask

  initial begin
    logic [8*ID_BYTES-1:0] a, b, c, d;
    int offs[5];
    int r, base, n;
    logic acc;

    tick();
    tick();
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_rpt_busy", 64'(rpt_busy), 64'd0);
    chk("rst_tag_drop", 64'(tag_drop), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic format and first-byte latency
    strobe(40'h0123456789);
    chk("lat_c1_start", 64'(tx_start), 64'd0);
    chk("lat_c1_busy", 64'(rpt_busy), 64'd1);
    tick();
    chk("lat_c2_start", 64'(tx_start), 64'd1);
    chk("lat_c2_data", 64'(tx_data), 64'h30);
    push_fmt(40'h0123456789);
    wait_idle("basic");
    check_report("basic");

    strobe(40'hABCDEF00FF);
    push_fmt(40'hABCDEF00FF);
    wait_idle("hex");
    check_report("hex");

    // Pending slot: third of three back-to-back IDs is dropped
    a = rnd_id(); b = rnd_id() ^ 40'h1; c = rnd_id() ^ 40'h2;
    strobe(a);
    strobe(b);
    strobe(c);
    chk("pend_drop_pulse", 64'(tag_drop), 64'd1);
    chk("pend_drop_cnt", 64'(drop_cnt), 64'd1);
    tick();
    chk("pend_drop_end", 64'(tag_drop), 64'd0);
    push_fmt(a);
    push_fmt(b);
    wait_idle("pend");
    chk("pend_pulses", 64'(drop_pulses), 64'd1);
    check_report("pend");

    // Saturation of the 2-bit drop counter
    do_reset();
    a = rnd_id(); b = rnd_id() ^ 40'h10;
    strobe(a);
    strobe(b);
    for (int i = 0; i < 5; i++) strobe(rnd_id() ^ 40'h100);
    tick();
    chk("sat_drop_cnt", 64'(drop_cnt), 64'd3);
    chk("sat_pulses", 64'(drop_pulses), 64'd5);
    push_fmt(a);
    push_fmt(b);
    wait_idle("sat");
    check_report("sat");

    // Dedup window: a repeat is ignored iff it lands within DEDUP cycles of the last reload
    do_reset();
    d = rnd_id() | 40'h1;
    offs = '{0, 50, 151, 251, 352};
    r = -100000;
    base = cyc;
    for (int k = 0; k < 5; k++) begin
      acc = !((offs[k] - r) <= DEDUP);
      r = offs[k];
      while (cyc < base + offs[k]) tick();
      strobe(d);
      if (acc) push_fmt(d);
    end
    wait_idle("dedup");
    chk("dedup_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("dedup_pulses", 64'(drop_pulses), 64'd0);
    check_report("dedup");

    // Random IDs, one report at a time
    for (int k = 0; k < 4; k++) begin
      a = rnd_id();
      strobe(a);
      push_fmt(a);
      wait_idle($sformatf("rnd%0d", k));
      check_report($sformatf("rnd%0d", k));
    end

    // Reset after the 4th byte aborts the report
    a = rnd_id() ^ 40'h5;
    strobe(a);
    n = 0;
    while (got.size() < 4 && n < 500) begin
      tick();
      n++;
    end
    chk("mid_reach4", 64'(got.size()), 64'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_tx_start", 64'(tx_start), 64'd0);
    chk("mid_tx_data", 64'(tx_data), 64'd0);
    chk("mid_rpt_busy", 64'(rpt_busy), 64'd0);
    chk("mid_tag_drop", 64'(tag_drop), 64'd0);
    chk("mid_drop_cnt", 64'(drop_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 150; i++) tick();
    chk("mid_no_more", 64'(got.size()), 64'd4);
    chk("mid_idle", 64'(rpt_busy), 64'd0);
    got.delete();
    b = rnd_id() ^ 40'h7;
    strobe(b);
    push_fmt(b);
    wait_idle("post");
    check_report("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
